// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS write-back stage: write-back source codes,
// load-size codes and the halt state encoding.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC8 = 2'b10;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extender.sv
// Combinational little-endian sub-word extraction with sign or zero extension
// for LB/LBU/LH/LHU/LW.
module load_extender
  import wb_pkg::*;
#(
  parameter int NB_REG = 32
) (
  input  logic [NB_REG-1:0] data,
  input  logic [1:0]        byte_offset,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  output logic [NB_REG-1:0] ext_data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        byte_sign;
  logic        half_sign;

  always_comb begin
    byte_val = data[7:0];
    case (byte_offset)
      2'd0:    byte_val = data[7:0];
      2'd1:    byte_val = data[15:8];
      2'd2:    byte_val = data[23:16];
      default: byte_val = data[31:24];
    endcase
  end

  // Halfword lane comes from offset bit 1 only; an odd offset is not trapped here.
  always_comb begin
    half_val = byte_offset[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    byte_sign = ~load_unsigned & byte_val[7];
    half_sign = ~load_unsigned & half_val[15];
    ext_data  = data;
    case (load_size)
      LOAD_BYTE: ext_data = {{(NB_REG-8){byte_sign}}, byte_val};
      LOAD_HALF: ext_data = {{(NB_REG-16){half_sign}}, half_val};
      default:   ext_data = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline latch with write-back source select, $0 write guard,
// retired-instruction counter and sticky HALT state for the debug unit.
module wb_stage
  import wb_pkg::*;
#(
  parameter int NB_REG        = 32,
  parameter int NB_ADDR_REG   = 5,
  parameter int NB_RETIRE_CNT = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_valid,
  input  logic [NB_REG-1:0]        i_alu_result,
  input  logic [NB_REG-1:0]        i_data_from_mem,
  input  logic [NB_REG-1:0]        i_pcplus8,
  input  logic [1:0]               i_byte_offset,
  input  logic [1:0]               i_wb_sel,
  input  logic [1:0]               i_load_size,
  input  logic                     i_load_unsigned,
  input  logic                     i_RegWrite,
  input  logic [NB_ADDR_REG-1:0]   i_rd_addr,
  input  logic                     i_halt_instr,
  output logic                     o_RegWrite,
  output logic [NB_ADDR_REG-1:0]   o_rd_addr,
  output logic [NB_REG-1:0]        o_data_to_reg,
  output logic [NB_RETIRE_CNT-1:0] o_retire_cnt,
  output logic                     o_halted
);

  logic [NB_REG-1:0] load_value;
  logic [NB_REG-1:0] wb_value;
  wb_state_e         state_q;
  wb_state_e         state_d;
  logic              running;
  logic              flush_now;
  logic              capture;
  logic              retire;
  logic              write_ok;

  load_extender #(
    .NB_REG(NB_REG)
  ) u_load_extender (
    .data          (i_data_from_mem),
    .byte_offset   (i_byte_offset),
    .load_size     (i_load_size),
    .load_unsigned (i_load_unsigned),
    .ext_data      (load_value)
  );

  // Code 11 is unused by the decoder and falls back to the ALU result.
  always_comb begin
    wb_value = i_alu_result;
    case (i_wb_sel)
      WB_SEL_MEM: wb_value = load_value;
      WB_SEL_PC8: wb_value = i_pcplus8;
      default:    wb_value = i_alu_result;
    endcase
  end

  always_comb begin
    running   = (state_q == ST_RUN);
    flush_now = running & i_flush;
    capture   = running & ~i_flush & ~i_stall;
    retire    = capture & i_valid;
    write_ok  = i_valid & i_RegWrite & (i_rd_addr != '0) & ~i_halt_instr;
    state_d   = state_q;
    case (state_q)
      ST_RUN:    if (retire && i_halt_instr) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Once halted nothing below moves until reset, so at most one write follows HALT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_RUN;
      o_RegWrite    <= 1'b0;
      o_rd_addr     <= '0;
      o_data_to_reg <= '0;
      o_retire_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (flush_now) begin
        o_RegWrite    <= 1'b0;
        o_rd_addr     <= '0;
        o_data_to_reg <= '0;
      end else if (capture) begin
        o_RegWrite    <= write_ok;
        o_rd_addr     <= i_rd_addr;
        o_data_to_reg <= wb_value;
      end
      if (retire) begin
        o_retire_cnt <= o_retire_cnt + NB_RETIRE_CNT'(1);
      end
    end
  end

  assign o_halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table-driven vectors with a scoreboard queue,
// plus hand-written stall/flush, halt and counter-wrap sequences.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_valid;
  logic [31:0] i_alu_result, i_data_from_mem, i_pcplus8;
  logic [1:0]  i_byte_offset, i_wb_sel, i_load_size;
  logic        i_load_unsigned, i_RegWrite, i_halt_instr;
  logic [4:0]  i_rd_addr;

  logic        o_RegWrite, o_halted;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_data_to_reg, o_retire_cnt;

  logic        rw4, halted4;
  logic [4:0]  rd4;
  logic [31:0] data4;
  logic [3:0]  cnt4;

  always #5 clk = ~clk;

  wb_stage #(.NB_REG(32), .NB_ADDR_REG(5), .NB_RETIRE_CNT(32)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_alu_result(i_alu_result), .i_data_from_mem(i_data_from_mem), .i_pcplus8(i_pcplus8),
    .i_byte_offset(i_byte_offset), .i_wb_sel(i_wb_sel), .i_load_size(i_load_size),
    .i_load_unsigned(i_load_unsigned), .i_RegWrite(i_RegWrite), .i_rd_addr(i_rd_addr),
    .i_halt_instr(i_halt_instr), .o_RegWrite(o_RegWrite), .o_rd_addr(o_rd_addr),
    .o_data_to_reg(o_data_to_reg), .o_retire_cnt(o_retire_cnt), .o_halted(o_halted)
  );

  wb_stage #(.NB_REG(32), .NB_ADDR_REG(5), .NB_RETIRE_CNT(4)) u_dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush), .i_valid(i_valid),
    .i_alu_result(i_alu_result), .i_data_from_mem(i_data_from_mem), .i_pcplus8(i_pcplus8),
    .i_byte_offset(i_byte_offset), .i_wb_sel(i_wb_sel), .i_load_size(i_load_size),
    .i_load_unsigned(i_load_unsigned), .i_RegWrite(i_RegWrite), .i_rd_addr(i_rd_addr),
    .i_halt_instr(i_halt_instr), .o_RegWrite(rw4), .o_rd_addr(rd4),
    .o_data_to_reg(data4), .o_retire_cnt(cnt4), .o_halted(halted4)
  );

  typedef struct {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc8;
    logic [1:0]  off;
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic        halt;
    logic        e_rw;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cnt;
    logic        halted;
  } exp_t;

  localparam logic [31:0] M = 32'h8877_6655;

  exp_t sb[$];
  exp_t model;
  vec_t tbl[15];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic vec_t mk(input logic valid, input logic reg_write, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc8,
                              input logic [1:0] off, input logic [1:0] sel, input logic [1:0] size,
                              input logic uns, input logic halt, input logic e_rw,
                              input logic [31:0] e_data);
    vec_t v;
    v.valid = valid; v.reg_write = reg_write; v.rd = rd; v.alu = alu; v.mem = mem;
    v.pc8 = pc8; v.off = off; v.sel = sel; v.size = size; v.uns = uns; v.halt = halt;
    v.e_rw = e_rw; v.e_data = e_data;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp("RegWrite", 32'(o_RegWrite), 32'(e.rw));
      cmp("rd_addr", 32'(o_rd_addr), 32'(e.rd));
      cmp("data_to_reg", o_data_to_reg, e.data);
      cmp("retire_cnt", o_retire_cnt, e.cnt);
      cmp("halted", 32'(o_halted), 32'(e.halted));
      cmp("retire_cnt4", 32'(cnt4), 32'(e.cnt[3:0]));
      cmp("halted4", 32'(halted4), 32'(e.halted));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input logic stall, input logic flush);
    i_valid = v.valid; i_RegWrite = v.reg_write; i_rd_addr = v.rd;
    i_alu_result = v.alu; i_data_from_mem = v.mem; i_pcplus8 = v.pc8;
    i_byte_offset = v.off; i_wb_sel = v.sel; i_load_size = v.size;
    i_load_unsigned = v.uns; i_halt_instr = v.halt;
    i_stall = stall; i_flush = flush;
    if (!model.halted) begin
      if (flush) begin
        model.rw = 1'b0; model.rd = '0; model.data = '0;
      end else if (!stall) begin
        model.rw = v.e_rw; model.rd = v.rd; model.data = v.e_data;
        if (v.valid) model.cnt = model.cnt + 32'd1;
        if (v.valid && v.halt) model.halted = 1'b1;
      end
    end
    sb.push_back(model);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    model = '{rw: 1'b0, rd: '0, data: '0, cnt: '0, halted: 1'b0};
    sb.push_back(model);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    i_rst = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_alu_result = '0; i_data_from_mem = '0; i_pcplus8 = '0; i_byte_offset = '0;
    i_wb_sel = '0; i_load_size = '0; i_load_unsigned = 1'b0; i_RegWrite = 1'b0;
    i_rd_addr = '0; i_halt_instr = 1'b0;
    model = '{rw: 1'b0, rd: '0, data: '0, cnt: '0, halted: 1'b0};

    //            vld rw rd  alu            mem pc8           off   sel         size       uns halt e_rw e_data
    tbl[0]  = mk(1, 1, 1,  32'h0,         M,  32'h0,       2'd0, WB_SEL_MEM, LOAD_BYTE, 0, 0, 1, 32'h0000_0055);
    tbl[1]  = mk(1, 1, 2,  32'h0,         M,  32'h0,       2'd1, WB_SEL_MEM, LOAD_BYTE, 0, 0, 1, 32'h0000_0066);
    tbl[2]  = mk(1, 1, 3,  32'h0,         M,  32'h0,       2'd2, WB_SEL_MEM, LOAD_BYTE, 0, 0, 1, 32'h0000_0077);
    tbl[3]  = mk(1, 1, 4,  32'h0,         M,  32'h0,       2'd3, WB_SEL_MEM, LOAD_BYTE, 0, 0, 1, 32'hFFFF_FF88);
    tbl[4]  = mk(1, 1, 5,  32'h0,         M,  32'h0,       2'd3, WB_SEL_MEM, LOAD_BYTE, 1, 0, 1, 32'h0000_0088);
    tbl[5]  = mk(1, 1, 6,  32'h0,         M,  32'h0,       2'd2, WB_SEL_MEM, LOAD_HALF, 0, 0, 1, 32'hFFFF_8877);
    tbl[6]  = mk(1, 1, 7,  32'h0,         M,  32'h0,       2'd2, WB_SEL_MEM, LOAD_HALF, 1, 0, 1, 32'h0000_8877);
    tbl[7]  = mk(1, 1, 8,  32'h0,         M,  32'h0,       2'd1, WB_SEL_MEM, LOAD_WORD, 0, 0, 1, 32'h8877_6655);
    tbl[8]  = mk(1, 1, 9,  32'h0,         M,  32'h0,       2'd3, WB_SEL_MEM, LOAD_HALF, 0, 0, 1, 32'hFFFF_8877);
    tbl[9]  = mk(1, 1, 10, 32'h0,         M,  32'h0,       2'd0, WB_SEL_MEM, LOAD_HALF, 1, 0, 1, 32'h0000_6655);
    tbl[10] = mk(1, 1, 31, 32'h1111_1111, M,  32'h0000_0040, 2'd0, WB_SEL_PC8, LOAD_WORD, 0, 0, 1, 32'h0000_0040);
    tbl[11] = mk(1, 1, 5,  32'hDEAD_BEEF, M,  32'h0000_0040, 2'd0, 2'b11,      LOAD_WORD, 0, 0, 1, 32'hDEAD_BEEF);
    tbl[12] = mk(1, 1, 0,  32'h0000_1234, M,  32'h0,       2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 0, 32'h0000_1234);
    tbl[13] = mk(0, 1, 7,  32'h0000_00AA, M,  32'h0,       2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 0, 32'h0000_00AA);
    tbl[14] = mk(1, 0, 9,  32'h0000_0055, M,  32'h0,       2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 0, 32'h0000_0055);

    $display("[TB] reset and table vectors");
    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(tbl[i], 1'b0, 1'b0);
    cmp("table_retire_total", o_retire_cnt, 32'd14);

    $display("[TB] stall and flush");
    applyStimulus(mk(1, 1, 3, 32'h1111_2222, M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 1, 32'h1111_2222), 1'b0, 1'b0);
    v = mk(1, 1, 4, 32'h9999_9999, M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 1, 32'h9999_9999);
    for (int i = 0; i < 3; i++) applyStimulus(v, 1'b1, 1'b0);
    cmp("stall_hold_data", o_data_to_reg, 32'h1111_2222);
    applyStimulus(v, 1'b1, 1'b1);
    applyStimulus(v, 1'b0, 1'b1);
    applyStimulus(v, 1'b0, 1'b0);

    $display("[TB] halt sequence");
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(mk(1, 1, 5'(i + 1), 32'(i + 100), M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 1, 32'(i + 100)), 1'b0, 1'b0);
    applyStimulus(mk(1, 1, 8, 32'h0000_0077, M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 1, 0, 32'h0000_0077), 1'b0, 1'b0);
    cmp("halt_retire_cnt", o_retire_cnt, 32'd5);
    v = mk(1, 1, 12, 32'h5A5A_5A5A, M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 1, 32'h5A5A_5A5A);
    applyStimulus(v, 1'b0, 1'b0);
    applyStimulus(v, 1'b0, 1'b1);
    applyStimulus(v, 1'b1, 1'b0);
    applyStimulus(v, 1'b0, 1'b0);
    i_stall = 1'b1;
    doReset();
    i_stall = 1'b0;
    applyStimulus(v, 1'b0, 1'b0);

    $display("[TB] counter wrap on 4-bit instance");
    doReset();
    for (int i = 0; i < 17; i++)
      applyStimulus(mk(1, 1, 5'(i + 1), 32'(i), M, 32'h0, 2'd0, WB_SEL_ALU, LOAD_WORD, 0, 0, 1, 32'(i)), 1'b0, 1'b0);
    cmp("wrap_cnt4", 32'(cnt4), 32'd1);
    cmp("wrap_cnt32", o_retire_cnt, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
